// File: rtl/cla_pkg.sv
// Shared constants, pipeline payload types and in-group carry helper for cla_lcu_pipe.
// The structs are sized for the default CLA_GROUPS; the top's GROUPS parameter must match it.
package cla_pkg;

  localparam int GROUP_W    = 4;
  localparam int CLA_GROUPS = 4;
  localparam int CLA_W      = GROUP_W * CLA_GROUPS;

  typedef struct packed {
    logic [CLA_W-1:0]      p;
    logic [CLA_W-1:0]      g;
    logic [CLA_GROUPS-1:0] grp_p;
    logic [CLA_GROUPS-1:0] grp_g;
    logic                  c0;
  } cla_s1_t;

  typedef struct packed {
    logic [CLA_W-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } cla_res_t;

  // Carries into each bit of one group, given the group's carry-in (bit 0 is ci itself).
  function automatic logic [GROUP_W-1:0] grp_carries(input logic [GROUP_W-1:0] p,
                                                     input logic [GROUP_W-1:0] g,
                                                     input logic               ci);
    logic [GROUP_W-1:0] c;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i < GROUP_W; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group_pg.sv
// Bit-level and 4-bit group propagate/generate for one nibble of the lookahead adder.
module cla_group_pg
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  output logic [GROUP_W-1:0] p,
  output logic [GROUP_W-1:0] g,
  output logic               grp_p,
  output logic               grp_g
);

  assign p     = a ^ b;
  assign g     = a & b;
  assign grp_p = &p;
  assign grp_g = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_lcu_pipe.sv
// Two-stage elastic carry-lookahead adder/subtractor: stage 1 forms p/g and group P/G,
// stage 2 is the lookahead carry unit. CLA_OVF_STICKY_EN adds clr_sticky/ovf_sticky.
module cla_lcu_pipe
  import cla_pkg::*;
#(
  parameter int GROUPS = CLA_GROUPS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [GROUP_W*GROUPS-1:0] a,
  input  logic [GROUP_W*GROUPS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GROUP_W*GROUPS-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    zero
`ifdef CLA_OVF_STICKY_EN
  ,
  input  logic                    clr_sticky,
  output logic                    ovf_sticky
`endif
);

  localparam int W = GROUP_W * GROUPS;

  logic            v1, v2;
  logic            ready1, ready2;
  logic            in_fire, mv12, out_fire;
  logic [W-1:0]    b_eff;
  logic [W-1:0]    p_s1, g_s1;
  logic [GROUPS-1:0] gp_s1, gg_s1;
  cla_s1_t         s1_d, s1_q;
  cla_res_t        res_d, res_q;

  assign ready2   = !v2 || out_ready;
  assign ready1   = !v1 || ready2;
  assign in_ready = ready1;
  assign in_fire  = in_valid && ready1;
  assign mv12     = v1 && ready2;
  assign out_fire = v2 && out_ready;

  assign b_eff = sub ? ~b : b;

  for (genvar k = 0; k < GROUPS; k++) begin : g_pg
    cla_group_pg u_pg (
      .a     (a[k*GROUP_W +: GROUP_W]),
      .b     (b_eff[k*GROUP_W +: GROUP_W]),
      .p     (p_s1[k*GROUP_W +: GROUP_W]),
      .g     (g_s1[k*GROUP_W +: GROUP_W]),
      .grp_p (gp_s1[k]),
      .grp_g (gg_s1[k])
    );
  end

  always_comb begin
    s1_d       = '0;
    s1_d.p     = p_s1;
    s1_d.g     = g_s1;
    s1_d.grp_p = gp_s1;
    s1_d.grp_g = gg_s1;
    s1_d.c0    = sub | cin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (in_fire) begin
      v1   <= 1'b1;
      s1_q <= s1_d;
    end else if (mv12) begin
      v1   <= 1'b0;
    end
  end

  // Group carries are flat sum-of-products over P/G so no carry ripples across groups.
  logic [GROUPS:0]    grp_c;
  logic [W:0]         c;
  logic [GROUP_W-1:0] gc;
  logic               acc, pp;

  always_comb begin
    grp_c    = '0;
    c        = '0;
    gc       = '0;
    acc      = 1'b0;
    pp       = 1'b0;
    res_d    = '0;
    grp_c[0] = s1_q.c0;
    for (int k = 0; k < GROUPS; k++) begin
      acc = s1_q.grp_g[k];
      pp  = s1_q.grp_p[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pp & s1_q.grp_g[j]);
        pp  = pp & s1_q.grp_p[j];
      end
      grp_c[k+1] = acc | (pp & s1_q.c0);
    end
    for (int k = 0; k < GROUPS; k++) begin
      gc = grp_carries(s1_q.p[k*GROUP_W +: GROUP_W], s1_q.g[k*GROUP_W +: GROUP_W], grp_c[k]);
      c[k*GROUP_W +: GROUP_W] = gc;
    end
    c[W]       = grp_c[GROUPS];
    res_d.sum  = s1_q.p ^ c[W-1:0];
    res_d.cout = grp_c[GROUPS];
    res_d.ovf  = c[W] ^ c[W-1];
    res_d.zero = ~|res_d.sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      res_q <= '0;
    end else if (mv12) begin
      v2    <= 1'b1;
      res_q <= res_d;
    end else if (out_fire) begin
      v2    <= 1'b0;
    end
  end

  assign out_valid = v2;
  assign sum       = res_q.sum;
  assign cout      = res_q.cout;
  assign ovf       = res_q.ovf;
  assign zero      = res_q.zero;

`ifdef CLA_OVF_STICKY_EN
  // Setting takes priority so an overflow delivered during a clear is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_fire && res_q.ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  // Sticky overflow tracking not built.
`endif

endmodule

// File: tb/tb_cla_lcu_pipe.sv
// Randomized and directed bench for cla_lcu_pipe against an arithmetic reference queue.
// Define CLA_OVF_STICKY_EN to also exercise the sticky overflow flag.
module tb_cla_lcu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [15:0] sum;
  logic        cout, ovf, zero;
`ifdef CLA_OVF_STICKY_EN
  logic        clr_sticky;
  logic        ovf_sticky;
  logic        sticky_m;
`endif

  cla_lcu_pipe #(.GROUPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
`ifdef CLA_OVF_STICKY_EN
    ,
    .clr_sticky(clr_sticky),
    .ovf_sticky(ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic last_ov, last_in_fire;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t ref_op(input logic [15:0] ra, input logic [15:0] rb,
                                  input logic rcin, input logic rsub, input int t);
    exp_t        e;
    logic [16:0] full;
    int          sres;
    if (rsub) begin
      full = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
      sres = int'($signed(ra)) - int'($signed(rb));
    end else begin
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rcin};
      sres = int'($signed(ra)) + int'($signed(rb)) + int'(rcin);
    end
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (sres > 32767) || (sres < -32768);
    e.zero = (full[15:0] == 16'd0);
    e.t    = t;
    return e;
  endfunction

  task automatic step();
    logic exp_ov, fire_in, fire_out;
    @(negedge clk);
    check_val("in_ready", in_ready, (q.size() < 2) || out_ready);
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    check_val("out_valid", out_valid, exp_ov);
    if (out_valid && q.size() > 0) begin
      check_val("sum", sum, q[0].sum);
      check_val("cout", cout, q[0].cout);
      check_val("ovf", ovf, q[0].ovf);
      check_val("zero", zero, q[0].zero);
    end
    fire_out = out_valid && out_ready;
    fire_in  = in_valid && in_ready;
`ifdef CLA_OVF_STICKY_EN
    check_val("ovf_sticky", ovf_sticky, sticky_m);
    if (fire_out && q.size() > 0 && q[0].ovf) sticky_m = 1'b1;
    else if (clr_sticky) sticky_m = 1'b0;
`endif
    if (fire_out && q.size() > 0) void'(q.pop_front());
    if (fire_in) q.push_back(ref_op(a, b, cin, sub, cyc));
    last_ov      = out_valid;
    last_in_fire = fire_in;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input logic [15:0] sa, input logic [15:0] sb,
                        input logic scin, input logic ssub);
    a = sa; b = sb; cin = scin; sub = ssub;
  endtask

  task automatic push_op(input logic [15:0] sa, input logic [15:0] sb,
                         input logic scin, input logic ssub);
    logic done;
    done = 1'b0;
    set_op(sa, sb, scin, ssub);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = last_in_fire;
    end
    if (!done) check_val("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check_val("drain_empty", q.size(), 0);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_left;
    int idx;
    logic seen_ov;
    logic [15:0] sa [4];
    logic [15:0] sb [4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
`ifdef CLA_OVF_STICKY_EN
    clr_sticky = 1'b0; sticky_m = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_sum", sum, 0);
    check_val("rst_flags", {cout, ovf, zero}, 0);
    rst_n = 1'b1;
    step();

    // Directed corner operations, one at a time with out_ready high.
    push_op(16'h00FF, 16'h0001, 1'b0, 1'b0); step(); step();
    push_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); step(); step();
    push_op(16'hFFFF, 16'h0000, 1'b1, 1'b0); step(); step();
    push_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); step(); step();
`ifdef CLA_OVF_STICKY_EN
    clr_sticky = 1'b1; step(); clr_sticky = 1'b0; step();
`endif
    push_op(16'h8000, 16'h0001, 1'b0, 1'b1); step(); step();
    push_op(16'h0005, 16'h0007, 1'b1, 1'b1); step(); step();
    drain();

    // Four back-to-back operations with a 3-cycle stall after the first result.
    for (int i = 0; i < 4; i++) begin
      sa[i] = 16'($urandom); sb[i] = 16'($urandom);
    end
    idx = 0; stall_left = 0; seen_ov = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (idx < 4 || q.size() > 0); i++) begin
      in_valid = (idx < 4);
      if (idx < 4) set_op(sa[idx], sb[idx], 1'b0, idx[0]);
      out_ready = (stall_left == 0);
      step();
      if (last_in_fire) idx++;
      if (stall_left > 0) stall_left--;
      if (last_ov && !seen_ov) begin
        seen_ov = 1'b1;
        stall_left = 3;
      end
    end
    check_val("stream_done", q.size(), 0);
    check_val("stream_count", idx, 4);
    drain();

    // Fill both stages, then assert reset asynchronously mid-cycle.
    out_ready = 1'b0;
    push_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    push_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    step();
    check_val("full_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_sum", sum, 0);
    check_val("arst_flags", {cout, ovf, zero}, 0);
    check_val("arst_in_ready", in_ready, 1);
`ifdef CLA_OVF_STICKY_EN
    check_val("arst_sticky", ovf_sticky, 0);
    sticky_m = 1'b0;
`endif
    q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    step(); step();
    push_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0); step(); step();
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      set_op(rnd16(), rnd16(), 1'($urandom), 1'($urandom));
`ifdef CLA_OVF_STICKY_EN
      clr_sticky = ($urandom_range(0, 9) == 0);
`endif
      step();
    end
`ifdef CLA_OVF_STICKY_EN
    clr_sticky = 1'b0;
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
